// File: rtl/pkt_dropper.sv
// pkt_dropper: 2-entry skid buffer that drops a stalled head packet.
// Define PKT_DROPPER_DROP_CNT_EN to build the saturating drop counter.
module pkt_dropper #(
  parameter int PACKET_BITS = 72,
  parameter int WAIT_BITS   = 32,
  parameter int CNT_BITS    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WAIT_BITS-1:0]   drop_wait_in,
  input  logic                   drop_cnt_clr_in,
  input  logic [PACKET_BITS-1:0] pkt_in_data_in,
  input  logic                   pkt_in_vld_in,
  output logic                   pkt_in_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_out_data_out,
  output logic                   pkt_out_vld_out,
  input  logic                   pkt_out_rdy_in,
  output logic [CNT_BITS-1:0]    drop_cnt_out
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_in_rdy;
  logic [PACKET_BITS-1:0] r_head;
  logic [PACKET_BITS-1:0] r_skid;
  logic [WAIT_BITS-1:0]   r_stall;

  logic                   w_out_vld;
  logic                   w_acc;
  logic                   w_xfer;
  logic                   w_stalled;
  logic                   w_drop;
  logic                   w_pop;
  logic [WAIT_BITS-1:0]   w_wait_m1;

  assign w_acc     = pkt_in_vld_in & r_in_rdy;
  assign w_xfer    = w_out_vld & pkt_out_rdy_in;
  assign w_stalled = w_out_vld & ~pkt_out_rdy_in;
  assign w_wait_m1 = drop_wait_in - WAIT_BITS'(1);
  assign w_drop    = (drop_wait_in != '0) & w_stalled
                   & (r_stall == w_wait_m1);
  assign w_pop     = w_xfer | w_drop;

  // State register; ready is registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_in_rdy <= (w_next_state != S_TWO);
    end
  end

  // Next-state logic: head leaves on transfer or drop
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) w_next_state = S_ONE;
      end
      S_ONE: begin
        if (w_pop && !w_acc)      w_next_state = S_EMPTY;
        else if (!w_pop && w_acc) w_next_state = S_TWO;
      end
      S_TWO: begin
        if (w_pop) w_next_state = S_ONE;
      end
      default: w_next_state = S_EMPTY;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    w_out_vld = (r_state != S_EMPTY);
  end

  assign pkt_out_vld_out  = w_out_vld;
  assign pkt_in_rdy_out   = r_in_rdy;
  assign pkt_out_data_out = r_head;

  // Head/skid datapath: skid refills head when head leaves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_acc) r_head <= pkt_in_data_in;
        end
        S_ONE: begin
          if (w_acc) begin
            if (w_pop) r_head <= pkt_in_data_in;
            else       r_skid <= pkt_in_data_in;
          end
        end
        S_TWO: begin
          if (w_pop) r_head <= r_skid;
        end
        default: ;
      endcase
    end
  end

  // Consecutive stall counter, saturating, cleared when head moves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (!w_out_vld || w_pop) begin
      r_stall <= '0;
    end else if (r_stall != '1) begin
      r_stall <= r_stall + WAIT_BITS'(1);
    end
  end

`ifdef PKT_DROPPER_DROP_CNT_EN
  logic [CNT_BITS-1:0] r_drop_cnt;

  // Drop counter: clear beats a simultaneous drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (drop_cnt_clr_in) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_BITS'(1);
    end
  end

  assign drop_cnt_out = r_drop_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = drop_cnt_clr_in;
  assign drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pkt_dropper.sv
// tb_pkt_dropper: directed + random checks of pkt_dropper
// against a queue-based reference model.
module tb_pkt_dropper;
  localparam int PB = 72;
  localparam int WB = 32;
  localparam int CB = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [WB-1:0] drop_wait_in = '0;
  logic          drop_cnt_clr_in = 1'b0;
  logic [PB-1:0] pkt_in_data_in = '0;
  logic          pkt_in_vld_in = 1'b0;
  logic          pkt_in_rdy_out;
  logic [PB-1:0] pkt_out_data_out;
  logic          pkt_out_vld_out;
  logic          pkt_out_rdy_in = 1'b0;
  logic [CB-1:0] drop_cnt_out;

  always #5 clk = ~clk;

  pkt_dropper #(
    .PACKET_BITS(PB),
    .WAIT_BITS(WB),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .drop_wait_in(drop_wait_in),
    .drop_cnt_clr_in(drop_cnt_clr_in),
    .pkt_in_data_in(pkt_in_data_in),
    .pkt_in_vld_in(pkt_in_vld_in),
    .pkt_in_rdy_out(pkt_in_rdy_out),
    .pkt_out_data_out(pkt_out_data_out),
    .pkt_out_vld_out(pkt_out_vld_out),
    .pkt_out_rdy_in(pkt_out_rdy_in),
    .drop_cnt_out(drop_cnt_out)
  );

  logic [PB-1:0] q[$];
  longint        stall;
  longint        dcnt;
  bit            mrdy;
  int            n_tests = 0;
  int            n_fail = 0;

  function automatic logic [PB-1:0] exp_cnt();
`ifdef PKT_DROPPER_DROP_CNT_EN
    return PB'(dcnt);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [PB-1:0] obs,
                     input logic [PB-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":vld"}, PB'(pkt_out_vld_out), PB'(q.size() > 0));
    if (q.size() > 0)
      chk({tag, ":data"}, pkt_out_data_out, q[0]);
    chk({tag, ":rdy"}, PB'(pkt_in_rdy_out), PB'(mrdy));
    chk({tag, ":cnt"}, PB'(drop_cnt_out), exp_cnt());
  endtask

  // One clock: model applies the rules to pre-edge inputs
  task automatic step(input string tag);
    bit vld;
    bit xfer;
    bit stalled;
    bit drop;
    bit acc;
    longint cmax;
    cmax = longint'((64'd1 << CB) - 64'd1);
    @(posedge clk);
    vld     = (q.size() > 0);
    xfer    = vld && pkt_out_rdy_in;
    stalled = vld && !pkt_out_rdy_in;
    drop    = (drop_wait_in != '0) && stalled
              && (stall + 1 == longint'(drop_wait_in));
    acc     = pkt_in_vld_in && mrdy;
    if (xfer || drop) void'(q.pop_front());
    if (drop_cnt_clr_in) dcnt = 0;
    else if (drop && dcnt < cmax) dcnt++;
    if (acc) q.push_back(pkt_in_data_in);
    stall = (stalled && !drop) ? stall + 1 : 0;
    mrdy  = (q.size() < 2);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    pkt_in_vld_in   = 1'b0;
    drop_cnt_clr_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({tag, ":rvld"}, PB'(pkt_out_vld_out), '0);
    chk({tag, ":rrdy"}, PB'(pkt_in_rdy_out), '0);
    chk({tag, ":rdata"}, pkt_out_data_out, '0);
    chk({tag, ":rcnt"}, PB'(drop_cnt_out), '0);
    q.delete();
    stall = 0;
    dcnt  = 0;
    mrdy  = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step({tag, ":rel"});
  endtask

  function automatic logic [PB-1:0] rnd_pkt();
    return PB'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    int vcyc;
    q.delete();
    stall = 0;
    dcnt  = 0;
    mrdy  = 1'b0;
    #2;
    do_reset("init");

    // back-to-back stream, no dropping
    drop_wait_in   = '0;
    pkt_out_rdy_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pkt_in_vld_in  = 1'b1;
      pkt_in_data_in = PB'(i + 1000);
      step("s033");
      chk("s033_lat", pkt_out_data_out, PB'(i + 1000));
    end
    pkt_in_vld_in = 1'b0;
    step("s033_end");

    // single packet dropped after 4 stalled cycles
    do_reset("s034r");
    drop_wait_in   = 32'd4;
    pkt_out_rdy_in = 1'b0;
    pkt_in_vld_in  = 1'b1;
    pkt_in_data_in = 72'hA5;
    step("s034_acc");
    pkt_in_vld_in = 1'b0;
    vcyc = pkt_out_vld_out ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step("s034");
      if (pkt_out_vld_out) vcyc++;
    end
    chk("s034_vldcyc", PB'(vcyc), PB'(4));

    // two packets, both dropped in turn
    do_reset("s035r");
    drop_wait_in   = 32'd4;
    pkt_out_rdy_in = 1'b0;
    pkt_in_vld_in  = 1'b1;
    pkt_in_data_in = 72'hAAAA;
    step("s035_a");
    pkt_in_data_in = 72'hBBBB;
    step("s035_b");
    pkt_in_vld_in = 1'b0;
    for (int i = 0; i < 10; i++) step("s035");

    // ready rises on the would-be drop cycle
    do_reset("s036r");
    drop_wait_in   = 32'd3;
    pkt_out_rdy_in = 1'b0;
    pkt_in_vld_in  = 1'b1;
    pkt_in_data_in = 72'h3C3C;
    step("s036_acc");
    pkt_in_vld_in = 1'b0;
    step("s036_s1");
    step("s036_s2");
    pkt_out_rdy_in = 1'b1;
    step("s036_x");
    pkt_out_rdy_in = 1'b0;
    step("s036_idle");

    // clear on drop cycle, then reset while full
    drop_wait_in  = 32'd2;
    pkt_in_vld_in = 1'b1;
    pkt_in_data_in = 72'h11;
    step("s037_x");
    pkt_in_vld_in = 1'b0;
    step("s037_s1");
    step("s037_d1");
    pkt_in_vld_in = 1'b1;
    pkt_in_data_in = 72'h22;
    step("s037_y");
    pkt_in_vld_in = 1'b0;
    step("s037_s2");
    drop_cnt_clr_in = 1'b1;
    step("s037_clr");
    drop_cnt_clr_in = 1'b0;
    drop_wait_in  = 32'd1;
    pkt_in_vld_in = 1'b1;
    pkt_in_data_in = 72'h33;
    step("s037_z");
    pkt_in_vld_in = 1'b0;
    step("s037_d2");
    drop_wait_in  = '0;
    pkt_in_vld_in = 1'b1;
    pkt_in_data_in = 72'h44;
    step("s037_a");
    pkt_in_data_in = 72'h55;
    step("s037_b");
    pkt_in_vld_in = 1'b0;
    step("s037_full");
    do_reset("s037_mid");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0)
        drop_wait_in = WB'($urandom_range(0, 6));
      pkt_in_vld_in   = ($urandom_range(0, 3) != 0);
      pkt_in_data_in  = rnd_pkt();
      pkt_out_rdy_in  = ($urandom_range(0, 2) == 0);
      drop_cnt_clr_in = ($urandom_range(0, 80) == 0);
      if (i == 1500) do_reset("rnd_rst");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_dropper.md
PKT_DROPPER -- requirements
Module: pkt_dropper

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 72, packet width in bits.
REQ-002 SHALL have parameter WAIT_BITS, default 32, width of stall limit and stall counter.
REQ-003 SHALL have parameter CNT_BITS, default 32, width of drop counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port drop_wait_in  input  WAIT_BITS  stall cycles tolerated before drop; 0 disables dropping.
REQ-007 SHALL have port drop_cnt_clr_in  input  1  synchronous clear of drop counter.
REQ-008 SHALL have port pkt_in_data_in  input  PACKET_BITS  packet from one router output channel.
REQ-009 SHALL have port pkt_in_vld_in  input  1  input packet valid.
REQ-010 SHALL have port pkt_in_rdy_out  output  1  input ready.
REQ-011 SHALL have port pkt_out_data_out  output  PACKET_BITS  packet towards HSSL channel.
REQ-012 SHALL have port pkt_out_vld_out  output  1  output valid.
REQ-013 SHALL have port pkt_out_rdy_in  input  1  output ready.
REQ-014 SHALL have port drop_cnt_out  output  CNT_BITS  number of dropped packets.

Function
REQ-015 SHALL be a 2-entry buffer (head register driving outputs, skid register) with states EMPTY, ONE, TWO.
REQ-016 SHALL transfer on a port when vld and rdy are both high at a rising clk edge.
REQ-017 SHALL drive pkt_in_rdy_out high iff state is not TWO, registered (no combinational path from pkt_out_rdy_in).
REQ-018 SHALL present an accepted packet on pkt_out_*_out the cycle after acceptance when the buffer was EMPTY (1-cycle latency).
REQ-019 SHALL preserve packet order and never duplicate a packet.
REQ-020 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on output transfer without accept; ONE->TWO on accept without output transfer; TWO->ONE on output transfer or drop; ONE stays on simultaneous accept and transfer.
REQ-021 SHALL keep a stall counter that increments each cycle pkt_out_vld_out=1 and pkt_out_rdy_in=0, and clears on output transfer, on drop, and in EMPTY.
REQ-022 SHALL drop the head packet when drop_wait_in!=0, the head is stalled this cycle, and the stall counter equals drop_wait_in-1, i.e. after exactly drop_wait_in consecutive stalled cycles.
REQ-023 SHALL, on drop, replace the head with the skid entry (TWO->ONE) or deassert pkt_out_vld_out (ONE->EMPTY) in the following cycle.
REQ-024 SHALL treat a cycle where pkt_out_rdy_in rises at the drop cycle as a transfer, not a drop (transfer wins).
REQ-025 SHALL allow a packet to be accepted in the same cycle as a drop of the head.
REQ-026 SHALL never drop when drop_wait_in==0; the stall counter SHALL saturate at all-ones.
REQ-027 SHALL use drop_wait_in as sampled each cycle; changing it mid-stall takes effect immediately.
REQ-028 SHALL keep pkt_out_data_out stable while pkt_out_vld_out=1 and no transfer or drop occurs.

Reset
REQ-029 SHALL, with reset_n low, force state EMPTY, pkt_out_vld_out=0, pkt_in_rdy_out=0, stall counter 0, drop_cnt_out=0, pkt_out_data_out=0, asynchronously.
REQ-030 SHALL assert pkt_in_rdy_out on the first rising clk edge after reset_n deasserts; buffered packets are discarded by reset mid-operation without counting.

Configuration
REQ-031 SHALL, with macro PKT_DROPPER_DROP_CNT_EN defined, increment drop_cnt_out by 1 per drop, saturating at all-ones, cleared by drop_cnt_clr_in (clear wins over a simultaneous drop: result 0).
REQ-032 SHALL, without PKT_DROPPER_DROP_CNT_EN, tie drop_cnt_out to 0 and ignore drop_cnt_clr_in, with no counter flops.

Verification
REQ-033 SHALL cover: drop_wait_in=0, pkt_out_rdy_in=1, 100 back-to-back packets -> all delivered in order, 1 per cycle, 1-cycle latency.
REQ-034 SHALL cover: drop_wait_in=4, one packet, pkt_out_rdy_in=0 -> vld high 4 cycles then low; drop_cnt_out=1.
REQ-035 SHALL cover: drop_wait_in=4, packets A,B, rdy=0 -> A dropped after 4 cycles, B presented next cycle, B dropped after 4 more; drop_cnt_out=2; pkt_in_rdy_out low while TWO.
REQ-036 SHALL cover: drop_wait_in=3, rdy rises on 3rd stalled cycle -> packet transferred, drop_cnt_out unchanged.
REQ-037 SHALL cover: drop pending and drop_cnt_clr_in=1 same cycle -> drop_cnt_out=0; reset_n low mid-TWO -> vld=0, counters 0 immediately.
REQ-038 SHALL cover: build without PKT_DROPPER_DROP_CNT_EN, scenario REQ-034 -> same packet behaviour, drop_cnt_out=0.
